mem_arbiter_16: RTL

MEM_ARBITER_16 -- requirements
Module: mem_arbiter_16

---
 rtl/mips16_pkg.sv | 31 +++
 rtl/mem_arbiter_16_timeout_cnt.sv | 38 +++
 rtl/mem_arbiter_16.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips16_pkg.sv
// -----------------------------------------------------------------------------
// mips16_pkg
// Shared types and defaults for the instruction/data memory arbiter.
//   state_e    : arbiter FSM states (IDLE, ISSUE, WAIT, ACK)
//   grant_e    : which requester owns the memory (GNT_IF fetch, GNT_D data)
//   DW_DEFAULT : default data/address width
//   MEM_TIMEOUT_DEFAULT : default number of WAIT cycles before abort
//   other_port : helper returning the requester that is not the given one
// -----------------------------------------------------------------------------
package mips16_pkg;

    localparam int DW_DEFAULT          = 16;
    localparam int MEM_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

    function automatic grant_e other_port(input grant_e g);
        return (g == GNT_IF) ? GNT_D : GNT_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_16_timeout_cnt.sv
// -----------------------------------------------------------------------------
// arb_timeout_cnt
// Counts cycles spent in WAIT so the arbiter can abort a stalled transaction.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   clear    : restart the count (driven while the command is being issued)
//   count_en : high while the arbiter sits in WAIT
//   expire   : high during the MEM_TIMEOUT-th WAIT cycle
// -----------------------------------------------------------------------------
module arb_timeout_cnt #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_reg;

    // cnt_reg holds the number of WAIT cycles already completed, so the
    // current WAIT cycle is number cnt_reg+1.
    assign expire = count_en && (cnt_reg == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (count_en && !expire) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_16.sv
// -----------------------------------------------------------------------------
// mem_arbiter_16
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory. One transaction at a time: IDLE -> ISSUE -> WAIT -> ACK.
//   clk, reset                    : clock, asynchronous active-low reset
//   if_req/if_addr                : fetch request and address
//   if_ack/if_rdata               : fetch completion pulse and read word
//   d_req/d_we/d_addr/d_wdata     : data-port request
//   d_ack/d_rdata                 : data completion pulse and load word
//   mem_en/mem_we/mem_addr/mem_wdata : memory command (mem_en one cycle)
//   mem_rdata/mem_ready           : memory response
//   bus_err                       : pulses with the ack of a timed-out access
//   busy                          : high whenever the FSM is not IDLE
// Build option: define ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; otherwise the data port always wins a tie.
// All outputs come straight from flops; their next values are derived from
// the next state so each output lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module mem_arbiter_16
    import mips16_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int DW          = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [DW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          bus_err,
    output logic          busy
);

    state_e        state_reg, state_next;
    grant_e        grant_reg, grant_next;
    grant_e        pick;
    logic          take_new;
    logic          expire;

    logic          mem_en_reg, mem_en_next;
    logic          mem_we_reg, mem_we_next;
    logic [DW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic          if_ack_reg, if_ack_next;
    logic          d_ack_reg, d_ack_next;
    logic [DW-1:0] if_rdata_reg, if_rdata_next;
    logic [DW-1:0] d_rdata_reg, d_rdata_next;
    logic          bus_err_reg, bus_err_next;
    logic          busy_reg, busy_next;

`ifdef ROUND_ROBIN_EN
    grant_e last_grant_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= GNT_IF;
        end else if (take_new) begin
            last_grant_reg <= pick;
        end
    end
`endif

    arb_timeout_cnt #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_reg == ISSUE),
        .count_en(state_reg == WAIT),
        .expire  (expire)
    );

    // Arbitration: in IDLE either port may win; in ACK only the port that
    // was not just served is considered, so the finishing requester's
    // still-high req is ignored for that cycle.
    always_comb begin
        pick     = GNT_IF;
        take_new = 1'b0;
        case (state_reg)
            IDLE: begin
                take_new = if_req || d_req;
                if (if_req && d_req) begin
`ifdef ROUND_ROBIN_EN
                    pick = other_port(last_grant_reg);
`else
                    pick = GNT_D;
`endif
                end else begin
                    pick = d_req ? GNT_D : GNT_IF;
                end
            end
            ACK: begin
                pick     = other_port(grant_reg);
                take_new = (grant_reg == GNT_D) ? if_req : d_req;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; mem_ready outside WAIT has no effect.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (take_new) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mem_ready || expire) state_next = ACK;
            ACK:     state_next = take_new ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the output flops.
    always_comb begin
        grant_next     = grant_reg;
        mem_en_next    = 1'b0;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if_ack_next    = 1'b0;
        d_ack_next     = 1'b0;
        bus_err_next   = 1'b0;
        if_rdata_next  = if_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        busy_next      = (state_next != IDLE);

        // The command flops double as the latched command; they are only
        // loaded on entry to ISSUE and cleared once WAIT is left.
        if (take_new) begin
            grant_next  = pick;
            mem_en_next = 1'b1;
            if (pick == GNT_D) begin
                mem_we_next    = d_we;
                mem_addr_next  = d_addr;
                mem_wdata_next = d_wdata;
            end else begin
                mem_we_next    = 1'b0;
                mem_addr_next  = if_addr;
                mem_wdata_next = '0;
            end
        end else if (state_next != WAIT) begin
            mem_we_next    = 1'b0;
            mem_addr_next  = '0;
            mem_wdata_next = '0;
        end

        if ((state_reg == WAIT) && (state_next == ACK)) begin
            if (grant_reg == GNT_D) begin
                d_ack_next = 1'b1;
            end else begin
                if_ack_next = 1'b1;
            end
            if (mem_ready) begin
                if (!mem_we_reg) begin
                    if (grant_reg == GNT_D) begin
                        d_rdata_next = mem_rdata;
                    end else begin
                        if_rdata_next = mem_rdata;
                    end
                end
            end else begin
                bus_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_reg     <= GNT_IF;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            d_ack_reg     <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            bus_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            grant_reg     <= grant_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_ack_reg    <= if_ack_next;
            d_ack_reg     <= d_ack_next;
            if_rdata_reg  <= if_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            bus_err_reg   <= bus_err_next;
            busy_reg      <= busy_next;
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_ack    = if_ack_reg;
    assign d_ack     = d_ack_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign bus_err   = bus_err_reg;
    assign busy      = busy_reg;

endmodule
